// File: rtl/seq_signed_divider.sv
// Sequential signed divider: restoring division on operand magnitudes, one
// quotient bit per clock, followed by a single sign-correction cycle.
module seq_signed_divider #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic             ovf
);

   localparam int unsigned W  = WIDTH;
   localparam int unsigned RW = WIDTH + 1;
   localparam int unsigned TW = WIDTH + 2;
   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t          state_q;
   logic [W-1:0]    q_q;       // |dividend| shifting out, quotient bits shifting in
   logic [W-1:0]    dvs_q;     // |divisor|
   logic [RW-1:0]   r_q;       // partial remainder
   logic [CW-1:0]   cnt_q;
   logic            qneg_q;    // operand signs differ
   logic            rneg_q;    // dividend negative

   logic [W-1:0]    dvd_abs;
   logic [W-1:0]    dvs_abs;
   logic [RW-1:0]   shift_r;
   logic [TW-1:0]   trial;
   logic            step_ge;
   logic            dbz;
   logic [W-1:0]    rmag;
   logic [W-1:0]    quot_fix;
   logic [W-1:0]    rem_fix;
   logic            ovf_fix;

   // Operand magnitudes, restoring step and sign-corrected result
   always_comb begin
      dvd_abs  = dividend[W-1] ? (~dividend + W'(1)) : dividend;
      dvs_abs  = divisor[W-1]  ? (~divisor  + W'(1)) : divisor;
      shift_r  = (r_q << 1) | RW'(q_q[W-1]);
      trial    = {1'b0, shift_r} - {2'b00, dvs_q};
      step_ge  = ~trial[TW-1];
      dbz      = (dvs_q == '0);
      // With a zero divisor no step ran, so q_q still holds |dividend|
      rmag     = dbz ? q_q : r_q[W-1:0];
      quot_fix = dbz ? '1 : (qneg_q ? (~q_q + W'(1)) : q_q);
      rem_fix  = rneg_q ? (~rmag + W'(1)) : rmag;
      // Only MIN / -1 yields a positive quotient with its top bit set
      ovf_fix  = ~dbz & ~qneg_q & q_q[W-1];
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         q_q         <= '0;
         dvs_q       <= '0;
         r_q         <= '0;
         cnt_q       <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         quot        <= '0;
         rem         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         ovf         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  q_q         <= dvd_abs;
                  dvs_q       <= dvs_abs;
                  r_q         <= '0;
                  cnt_q       <= '0;
                  qneg_q      <= dividend[W-1] ^ divisor[W-1];
                  rneg_q      <= dividend[W-1];
                  busy        <= 1'b1;
                  div_by_zero <= 1'b0;
                  ovf         <= 1'b0;
                  state_q     <= (divisor == '0) ? FIX : CALC;
               end
            end
            CALC: begin
               r_q   <= step_ge ? trial[RW-1:0] : shift_r;
               q_q   <= {q_q[W-2:0], step_ge};
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               quot        <= quot_fix;
               rem         <= rem_fix;
               div_by_zero <= dbz;
               ovf         <= ovf_fix;
               done        <= 1'b1;
               busy        <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider at WIDTH=4: directed vectors,
// handshake corner cases, mid-operation reset and a full operand sweep.
module tb_seq_signed_divider;

   localparam int unsigned WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic             ovf;

   seq_signed_divider #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .quot       (quot),
      .rem        (rem),
      .busy       (busy),
      .done       (done),
      .div_by_zero(div_by_zero),
      .ovf        (ovf)
   );

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] q;
      logic [3:0] r;
      logic       dz;
      logic       ov;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   int         n_chk  = 0;
   int         n_pass = 0;
   int         cyc    = 0;
   logic [3:0] last_q = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      else n_pass++;
   endtask

   // Reference: truncating signed division with the two boundary cases
   function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
      exp_t e;
      int   ai;
      int   bi;
      ai   = int'($signed(a));
      bi   = int'($signed(b));
      e.a  = a;
      e.b  = b;
      e.dz = 1'b0;
      e.ov = 1'b0;
      e.cyc = 0;
      if (bi == 0) begin
         e.q  = 4'hF;
         e.r  = a;
         e.dz = 1'b1;
      end else if (ai == -8 && bi == -1) begin
         e.q  = 4'h8;
         e.r  = 4'h0;
         e.ov = 1'b1;
      end else begin
         e.q = 4'(ai / bi);
         e.r = 4'(ai % bi);
      end
      return e;
   endfunction

   // Monitor: every done pulse pops one expectation
   always @(negedge clk) begin
      exp_t e;
      int   v;
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL spurious_done: got done=1 expected no result pending (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("quot", 32'(quot), 32'(e.q));
            chk("rem", 32'(rem), 32'(e.r));
            chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
            chk("ovf", 32'(ovf), 32'(e.ov));
            chk("latency_cycle", 32'(cyc), 32'(e.cyc));
            chk("busy_low_at_done", 32'(busy), 32'd0);
            if (!e.dz && !e.ov) begin
               v = int'($signed(quot)) * int'($signed(e.b)) + int'($signed(rem));
               chk("invariant", 32'(v), 32'(int'($signed(e.a))));
            end
         end
      end
   end

   // Issue one operation at a negedge and wait (bounded) for its done pulse
   task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [3:0] q,
                      input logic [3:0] r, input logic dz, input logic ov, input bit glitch);
      exp_t e;
      int   k;
      e.a   = a;
      e.b   = b;
      e.q   = q;
      e.r   = r;
      e.dz  = dz;
      e.ov  = ov;
      e.cyc = cyc + 1 + ((b == 4'h0) ? 1 : WIDTH + 1);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      sb.push_back(e);
      @(negedge clk);
      start    = 1'b0;
      dividend = ~a;
      divisor  = ~b;
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("flags_cleared", 32'({div_by_zero, ovf}), 32'd0);
      chk("quot_held", 32'(quot), 32'(last_q));
      if (glitch) begin
         @(negedge clk);
         start    = 1'b1;
         dividend = 4'd1;
         divisor  = 4'd1;
         @(negedge clk);
         start    = 1'b0;
      end
      for (k = 0; k < 20 && !done; k++) @(negedge clk);
      if (!done) begin
         n_chk++;
         $display("FAIL done_timeout: got no done expected done for %0h/%0h", a, b);
      end
      last_q = q;
   endtask

   initial begin
      exp_t m;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", 32'({quot, rem, busy, done, div_by_zero, ovf}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors, hand-computed: a, b, quot, rem, dbz, ovf
      run(4'd7,  4'd2,  4'h3, 4'h1, 1'b0, 1'b0, 1'b0);   //  7 /  2 =  3 r  1
      run(4'h9,  4'd2,  4'hD, 4'hF, 1'b0, 1'b0, 1'b0);   // -7 /  2 = -3 r -1
      run(4'd7,  4'hE,  4'hD, 4'h1, 1'b0, 1'b0, 1'b0);   //  7 / -2 = -3 r  1
      run(4'h9,  4'hE,  4'h3, 4'hF, 1'b0, 1'b0, 1'b0);   // -7 / -2 =  3 r -1
      run(4'h8,  4'hF,  4'h8, 4'h0, 1'b0, 1'b1, 1'b0);   // -8 / -1 overflow
      run(4'd5,  4'h0,  4'hF, 4'h5, 1'b1, 1'b0, 1'b0);   //  5 /  0
      run(4'd0,  4'd3,  4'h0, 4'h0, 1'b0, 1'b0, 1'b0);   //  0 /  3
      run(4'h8,  4'h0,  4'hF, 4'h8, 1'b1, 1'b0, 1'b0);   // -8 /  0
      run(4'h0,  4'h0,  4'hF, 4'h0, 1'b1, 1'b0, 1'b0);   //  0 /  0
      run(4'h8,  4'd1,  4'h8, 4'h0, 1'b0, 1'b0, 1'b0);   // -8 /  1 = -8
      run(4'h8,  4'd2,  4'hC, 4'h0, 1'b0, 1'b0, 1'b0);   // -8 /  2 = -4
      run(4'd7,  4'd7,  4'h1, 4'h0, 1'b0, 1'b0, 1'b0);   //  7 /  7
      run(4'd3,  4'd7,  4'h0, 4'h3, 1'b0, 1'b0, 1'b0);   //  3 /  7
      run(4'hF,  4'd7,  4'h0, 4'hF, 1'b0, 1'b0, 1'b0);   // -1 /  7 = 0 r -1
      run(4'd7,  4'h8,  4'h0, 4'h7, 1'b0, 1'b0, 1'b0);   //  7 / -8
      run(4'h8,  4'h8,  4'h1, 4'h0, 1'b0, 1'b0, 1'b0);   // -8 / -8

      // Start while busy is ignored, then back-to-back issue in the done cycle
      run(4'd6,  4'd3,  4'h2, 4'h0, 1'b0, 1'b0, 1'b1);
      run(4'd4,  4'd2,  4'h2, 4'h0, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of 7/2 aborts without a done pulse
      @(negedge clk);
      start    = 1'b1;
      dividend = 4'd7;
      divisor  = 4'd2;
      @(negedge clk);
      start    = 1'b0;
      repeat (2) @(negedge clk);
      chk("busy_before_abort", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", 32'({quot, rem, busy, done, div_by_zero, ovf}), 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      last_q = '0;
      repeat (10) @(negedge clk);
      chk("abort_no_result", 32'({quot, rem, busy}), 32'd0);

      // Full sweep against the reference model
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            m = model(4'(a), 4'(b));
            run(m.a, m.b, m.q, m.r, m.dz, m.ov, 1'b0);
         end
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no end of test expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
